// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Divisors are half-period lengths minus one, counted in board-clock cycles.
package clkdiv_pkg;

  localparam int unsigned BOARD_HZ    = 32'd50_000_000;
  localparam int unsigned DIV_W       = 32'd25;
  localparam int unsigned DEFAULT_DIV = 32'd2_500_000;

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_COUNT   = 2'd1,
    ACT_TERM    = 2'd2,
    ACT_RECOVER = 2'd3
  } chan_act_e;

  // Divisor producing out_hz on clockout; saturates for out-of-range requests.
  function automatic logic [DIV_W-1:0] half_period_div(input int unsigned out_hz);
    logic [DIV_W-1:0] res;
    if (out_hz == 32'd0) begin
      res = {DIV_W{1'b1}};
    end else if (out_hz >= (BOARD_HZ / 32'd2)) begin
      res = {DIV_W{1'b0}};
    end else begin
      res = DIV_W'((BOARD_HZ / (32'd2 * out_hz)) - 32'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: half-period counter, shadowed divisor, toggle and tick.
// A new divisor only takes effect at a terminal count, so no runt pulses occur.
module clkdiv_chan #(
  parameter int unsigned W           = 32'd25,
  parameter int unsigned DEFAULT_DIV = 32'd2_500_000
) (
  input  logic         clockin,
  input  logic         reset,
  input  logic         enable,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  output logic         clockout,
  output logic         tick,
  output logic         pending
);
  import clkdiv_pkg::*;

  localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);

  logic [W-1:0] count;
  logic [W-1:0] div;
  logic [W-1:0] shadow;
  logic [W-1:0] eff_div;
  chan_act_e    act;

  // Classify what this edge does to the counter.
  always_comb begin
    act = ACT_HOLD;
    if (!enable) begin
      act = ACT_HOLD;
    end else if (count < div) begin
      act = ACT_COUNT;
    end else if (count == div) begin
      act = ACT_TERM;
    end else begin
      act = ACT_RECOVER;
    end
  end

  // A same-edge write beats the shadow, which beats the current divisor.
  always_comb begin
    eff_div = div;
    if (wr) begin
      eff_div = wr_div;
    end else if (pending) begin
      eff_div = shadow;
    end else begin
      eff_div = div;
    end
  end

  // Counter, divisor and output registers.
  always_ff @(posedge clockin) begin
    if (reset) begin
      count    <= {W{1'b0}};
      div      <= DIV_RST;
      shadow   <= DIV_RST;
      pending  <= 1'b0;
      clockout <= 1'b0;
      tick     <= 1'b0;
    end else begin
      case (act)
        ACT_COUNT: begin
          count <= count + {{(W-1){1'b0}}, 1'b1};
          tick  <= 1'b0;
        end
        ACT_TERM: begin
          count    <= {W{1'b0}};
          clockout <= ~clockout;
          tick     <= 1'b1;
          div      <= eff_div;
        end
        ACT_RECOVER: begin
          count <= {W{1'b0}};
          tick  <= 1'b0;
        end
        default: begin
          tick <= 1'b0;
        end
      endcase

      // A write landing on the terminal edge is consumed immediately.
      if (wr) begin
        shadow  <= wr_div;
        pending <= (act != ACT_TERM);
      end else if (act == ACT_TERM) begin
        pending <= 1'b0;
      end else begin
        pending <= pending;
      end
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// N independent programmable clock dividers sharing one divisor write port.
// Writes addressed beyond the last channel match no strobe and are dropped.
module clkdiv_multi #(
  parameter  int unsigned N           = 32'd4,
  parameter  int unsigned W           = clkdiv_pkg::DIV_W,
  parameter  int unsigned DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV,
  localparam int unsigned CW          = (N > 32'd1) ? $clog2(N) : 32'd1
) (
  input  logic          clockin,
  input  logic          reset,
  input  logic [N-1:0]  enable,
  input  logic          load,
  input  logic [CW-1:0] load_ch,
  input  logic [W-1:0]  load_div,
  output logic [N-1:0]  clockout,
  output logic [N-1:0]  tick,
  output logic [N-1:0]  pending
);
  import clkdiv_pkg::*;

  logic [N-1:0] wr;

  // Decode the shared write port into one strobe per channel.
  always_comb begin
    wr = {N{1'b0}};
    for (int i = 0; i < int'(N); i++) begin
      wr[i] = load && (load_ch == CW'(i));
    end
  end

  for (genvar i = 0; i < int'(N); i++) begin : g_chan
    clkdiv_chan #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clockin  (clockin),
      .reset    (reset),
      .enable   (enable[i]),
      .wr       (wr[i]),
      .wr_div   (load_div),
      .clockout (clockout[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: directed table, corner sequences,
// then random traffic against a half-period-length reference model.
module tb_clkdiv_multi;

  localparam int NC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] enable;
  logic       load;
  logic [1:0] load_ch;
  logic [3:0] load_div;
  logic [2:0] clockout;
  logic [2:0] tick;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;

  // Reference model: enabled cycles spent in the current half period,
  // its length, and an optional queued new length (-1 when none).
  int m_run[NC];
  int m_half[NC];
  int m_q[NC];
  bit m_clk[NC];
  bit m_tick[NC];
  bit m_pend[NC];

  typedef struct {
    logic       rst;
    logic [2:0] en;
    logic       ld;
    logic [1:0] ch;
    logic [3:0] dv;
    logic [2:0] co;
    logic [2:0] tk;
    logic [2:0] pd;
  } vec_t;

  vec_t tbl[11];

  clkdiv_multi #(.N(3), .W(4), .DEFAULT_DIV(3)) dut (
    .clockin  (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .load_ch  (load_ch),
    .load_div (load_div),
    .clockout (clockout),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit wr;
    bit term;
    for (int c = 0; c < NC; c++) begin
      if (reset) begin
        m_run[c] = 0; m_half[c] = 4; m_q[c] = -1;
        m_clk[c] = 1'b0; m_tick[c] = 1'b0; m_pend[c] = 1'b0;
      end else begin
        wr   = load && (int'(load_ch) == c);
        term = enable[c] && (m_run[c] + 1 == m_half[c]);
        m_tick[c] = 1'b0;
        if (enable[c]) begin
          if (term) begin
            m_clk[c]  = ~m_clk[c];
            m_tick[c] = 1'b1;
            m_run[c]  = 0;
            if (wr) m_half[c] = int'(load_div) + 1;
            else if (m_q[c] >= 0) m_half[c] = m_q[c] + 1;
            m_q[c]    = -1;
            m_pend[c] = 1'b0;
          end else begin
            m_run[c]++;
          end
        end
        if (wr && !term) begin
          m_q[c]    = int'(load_div);
          m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic r, input logic [2:0] en, input logic ld,
                       input logic [1:0] ch, input logic [3:0] dv);
    reset = r; enable = en; load = ld; load_ch = ch; load_div = dv;
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 3'b111, 1'b0, 2'd0, 4'd0);
    step();
    chk3("rst_co", clockout, 3'b000);
    chk3("rst_tk", tick, 3'b000);
    chk3("rst_pd", pending, 3'b000);
    drive(1'b0, 3'b111, 1'b0, 2'd0, 4'd0);
  endtask

  initial begin
    logic [2:0] mco, mtk, mpd;

    //             rst   en      ld    ch    dv     co      tk      pd
    tbl[0]  = '{1'b1, 3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{1'b0, 3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 3'b000, 3'b000};
    tbl[2]  = '{1'b0, 3'b111, 1'b1, 2'd0, 4'd1, 3'b000, 3'b000, 3'b001};
    tbl[3]  = '{1'b0, 3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 3'b000, 3'b001};
    tbl[4]  = '{1'b0, 3'b111, 1'b0, 2'd0, 4'd0, 3'b111, 3'b111, 3'b000};
    tbl[5]  = '{1'b0, 3'b111, 1'b0, 2'd0, 4'd0, 3'b111, 3'b000, 3'b000};
    tbl[6]  = '{1'b0, 3'b111, 1'b0, 2'd0, 4'd0, 3'b110, 3'b001, 3'b000};
    tbl[7]  = '{1'b0, 3'b111, 1'b0, 2'd0, 4'd0, 3'b110, 3'b000, 3'b000};
    tbl[8]  = '{1'b0, 3'b111, 1'b0, 2'd0, 4'd0, 3'b001, 3'b111, 3'b000};
    tbl[9]  = '{1'b0, 3'b111, 1'b0, 2'd0, 4'd0, 3'b001, 3'b000, 3'b000};
    tbl[10] = '{1'b0, 3'b111, 1'b0, 2'd0, 4'd0, 3'b000, 3'b001, 3'b000};

    drive(1'b1, 3'b111, 1'b0, 2'd0, 4'd0);
    step();

    // Default divisor plus a mid-half-period divisor change on channel 0
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].ch, tbl[i].dv);
      step();
      chk3($sformatf("tbl%0d_co", i), clockout, tbl[i].co);
      chk3($sformatf("tbl%0d_tk", i), tick, tbl[i].tk);
      chk3($sformatf("tbl%0d_pd", i), pending, tbl[i].pd);
    end

    // Write of divisor 0 on channel 0's terminal edge applies at once
    do_reset();
    repeat (3) step();
    drive(1'b0, 3'b111, 1'b1, 2'd0, 4'd0);
    step();
    chk1("term_wr_co", clockout[0], 1'b1);
    chk1("term_wr_tk", tick[0], 1'b1);
    chk1("term_wr_pd", pending[0], 1'b0);
    drive(1'b0, 3'b111, 1'b0, 2'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1($sformatf("div0_co%0d", i), clockout[0], logic'(i[0]));
      chk1($sformatf("div0_tk%0d", i), tick[0], 1'b1);
      chk1($sformatf("div0_pd%0d", i), pending[0], 1'b0);
    end

    // Two writes, last wins; out-of-range channel ignored
    do_reset();
    drive(1'b0, 3'b111, 1'b1, 2'd1, 4'd5);
    step();
    chk3("wr2a_pd", pending, 3'b010);
    drive(1'b0, 3'b111, 1'b1, 2'd1, 4'd2);
    step();
    drive(1'b0, 3'b111, 1'b1, 2'd3, 4'd0);
    step();
    chk3("oor_pd", pending, 3'b010);
    chk3("oor_co", clockout, 3'b000);
    drive(1'b0, 3'b111, 1'b0, 2'd0, 4'd0);
    step();
    chk3("wr2_e4_co", clockout, 3'b111);
    chk3("wr2_e4_pd", pending, 3'b000);
    step();
    step();
    chk1("wr2_e6_co", clockout[1], 1'b1);
    chk1("wr2_e6_tk", tick[1], 1'b0);
    step();
    chk1("wr2_e7_co", clockout[1], 1'b0);
    chk1("wr2_e7_tk", tick[1], 1'b1);
    step();
    chk3("wr2_e8_co", clockout, 3'b000);
    chk3("wr2_e8_tk", tick, 3'b101);

    // Channel 1 frozen for 5 cycles at count 2
    do_reset();
    step();
    step();
    drive(1'b0, 3'b101, 1'b0, 2'd0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk1($sformatf("frz_tk%0d", i), tick[1], 1'b0);
      chk1($sformatf("frz_co%0d", i), clockout[1], 1'b0);
    end
    drive(1'b0, 3'b111, 1'b0, 2'd0, 4'd0);
    step();
    chk1("resume1_co", clockout[1], 1'b0);
    step();
    chk1("resume2_co", clockout[1], 1'b1);
    chk1("resume2_tk", tick[1], 1'b1);

    // Reset while a write is pending and clockout is high
    do_reset();
    repeat (4) step();
    drive(1'b0, 3'b111, 1'b1, 2'd0, 4'd2);
    step();
    chk3("prst_pd", pending, 3'b001);
    chk3("prst_co", clockout, 3'b111);
    drive(1'b1, 3'b111, 1'b0, 2'd0, 4'd0);
    step();
    chk3("mrst_co", clockout, 3'b000);
    chk3("mrst_tk", tick, 3'b000);
    chk3("mrst_pd", pending, 3'b000);
    drive(1'b0, 3'b111, 1'b0, 2'd0, 4'd0);
    repeat (3) step();
    chk3("post_e3_co", clockout, 3'b000);
    step();
    chk3("post_e4_co", clockout, 3'b111);
    chk3("post_e4_tk", tick, 3'b111);

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0),
            {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)},
            ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 6)));
      step();
      for (int c = 0; c < NC; c++) begin
        mco[c] = m_clk[c];
        mtk[c] = m_tick[c];
        mpd[c] = m_pend[c];
      end
      chk3($sformatf("rnd%0d_co", i), clockout, mco);
      chk3($sformatf("rnd%0d_tk", i), tick, mtk);
      chk3($sformatf("rnd%0d_pd", i), pending, mpd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
